// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and instruction fetch handshake.
// A two-state FSM (FETCH/HOLD) requests one instruction word at pc_atual,
// latches it on acknowledge, then waits for the pipeline to release the
// stall before loading the next PC supplied by the next-PC mux.
// Optional build macro: PC_ALIGN_CHECK_EN -- when defined, misaligned next-PC
// values are force-aligned to a word boundary and a sticky error flag is set.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] proximo_pc,
  input  logic        stall,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_atual,
  output logic [31:0] pc_mais4,
  output logic [31:0] instrucao,
  output logic        instr_valida,
  output logic [31:0] contador_instr,
  output logic        erro_alinhamento
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic        valid_reg;
  logic [31:0] count_reg;
  logic [31:0] pc_load;

  // A word arrives only while requesting; the PC advances only once the
  // held instruction has been released by the pipeline.
  logic take_word;
  logic advance_pc;

  assign take_word  = (state_reg == FETCH) && imem_ack;
  assign advance_pc = (state_reg == HOLD) && !stall;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;
  logic align_err_reg;

  // Low two bits of the next PC are discarded so fetches stay word aligned.
  assign pc_load    = {proximo_pc[31:2], 2'b00};
  assign misaligned = |proximo_pc[1:0];

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      align_err_reg <= 1'b0;
    end else if (advance_pc && misaligned) begin
      align_err_reg <= 1'b1;
    end
  end

  assign erro_alinhamento = align_err_reg;
`else
  assign pc_load          = proximo_pc;
  assign erro_alinhamento = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: stall is irrelevant in FETCH, ack is irrelevant in HOLD.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: if (imem_ack) state_next = HOLD;
      HOLD:  if (!stall)   state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Output decode: request is asserted for the whole FETCH state.
  always_comb begin
    imem_req = 1'b0;
    if (state_reg == FETCH) begin
      imem_req = 1'b1;
    end
  end

  // Datapath registers: PC, fetched word, valid flag and update counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg    <= RESET_VECTOR;
      instr_reg <= 32'h0000_0000;
      valid_reg <= 1'b0;
      count_reg <= 32'h0000_0000;
    end else if (take_word) begin
      instr_reg <= imem_data;
      valid_reg <= 1'b1;
    end else if (advance_pc) begin
      pc_reg    <= pc_load;
      valid_reg <= 1'b0;
      count_reg <= count_reg + 32'd1;
    end
  end

  assign pc_atual       = pc_reg;
  assign imem_addr      = pc_reg;
  assign pc_mais4       = pc_reg + 32'd4;
  assign instrucao      = instr_reg;
  assign instr_valida   = valid_reg;
  assign contador_instr = count_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed vector table, PC wrap sequence and
// randomized traffic checked against a rule-level reference model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0040;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] EXP_MIS_PC = 32'h0000_0044;
  localparam logic        EXP_ERR    = 1'b1;
  localparam bit          ALIGN_ON   = 1'b1;
`else
  localparam logic [31:0] EXP_MIS_PC = 32'h0000_0046;
  localparam logic        EXP_ERR    = 1'b0;
  localparam bit          ALIGN_ON   = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] proximo_pc;
  logic        stall;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_atual;
  logic [31:0] pc_mais4;
  logic [31:0] instrucao;
  logic        instr_valida;
  logic [31:0] contador_instr;
  logic        erro_alinhamento;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
    .clock            (clock),
    .reset            (reset),
    .proximo_pc       (proximo_pc),
    .stall            (stall),
    .imem_ack         (imem_ack),
    .imem_data        (imem_data),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .pc_atual         (pc_atual),
    .pc_mais4         (pc_mais4),
    .instrucao        (instrucao),
    .instr_valida     (instr_valida),
    .contador_instr   (contador_instr),
    .erro_alinhamento (erro_alinhamento)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        ack;
    logic [31:0] data;
    logic [31:0] nxt;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic [31:0] exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  task automatic add(input logic rst, input logic stl, input logic ack,
                     input logic [31:0] data, input logic [31:0] nxt,
                     input logic ereq, input logic [31:0] epc,
                     input logic [31:0] einstr, input logic evalid,
                     input logic [31:0] ecnt, input logic eerr);
    vecs[n_vec].rst       = rst;
    vecs[n_vec].stl       = stl;
    vecs[n_vec].ack       = ack;
    vecs[n_vec].data      = data;
    vecs[n_vec].nxt       = nxt;
    vecs[n_vec].exp_req   = ereq;
    vecs[n_vec].exp_pc    = epc;
    vecs[n_vec].exp_instr = einstr;
    vecs[n_vec].exp_valid = evalid;
    vecs[n_vec].exp_cnt   = ecnt;
    vecs[n_vec].exp_err   = eerr;
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic ack,
                       input logic [31:0] data, input logic [31:0] nxt);
    reset      = rst;
    stall      = stl;
    imem_ack   = ack;
    imem_data  = data;
    proximo_pc = nxt;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ereq, input logic [31:0] epc,
                           input logic [31:0] einstr, input logic evalid,
                           input logic [31:0] ecnt, input logic eerr);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, ereq});
    chk({tag, ".imem_addr"}, imem_addr, epc);
    chk({tag, ".pc_atual"}, pc_atual, epc);
    chk({tag, ".pc_mais4"}, pc_mais4, epc + 32'd4);
    chk({tag, ".instrucao"}, instrucao, einstr);
    chk({tag, ".instr_valida"}, {31'd0, instr_valida}, {31'd0, evalid});
    chk({tag, ".contador_instr"}, contador_instr, ecnt);
    chk({tag, ".erro_alinhamento"}, {31'd0, erro_alinhamento}, {31'd0, eerr});
  endtask

  // Reference model state, described in terms of the handshake rules:
  // waiting_release is true between accepting a word and the PC update.
  bit          waiting_release;
  logic [31:0] m_pc, m_instr, m_cnt;
  bit          m_valid, m_err;

  task automatic model_edge(input logic rst, input logic stl, input logic ack,
                            input logic [31:0] data, input logic [31:0] nxt);
    if (rst) begin
      waiting_release = 0;
      m_pc = RV; m_instr = 0; m_valid = 0; m_cnt = 0; m_err = 0;
    end else if (!waiting_release) begin
      if (ack) begin
        m_instr = data;
        m_valid = 1;
        waiting_release = 1;
      end
    end else if (!stl) begin
      if (ALIGN_ON && (nxt % 4 != 0)) begin
        m_pc  = nxt - (nxt % 4);
        m_err = 1;
      end else begin
        m_pc = nxt;
      end
      m_cnt = m_cnt + 1;
      m_valid = 0;
      waiting_release = 0;
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Directed table: startup fetch, stalled hold, delayed ack, reset in HOLD,
    // misaligned update with sticky flag.
    add(1, 0, 0, 32'h0, 32'h0,               1, RV, 32'h0, 0, 0, 0);
    add(0, 0, 1, 32'h2008_0005, 32'h0,       0, RV, 32'h2008_0005, 1, 0, 0);
    add(0, 1, 0, 32'h0, 32'h44,              0, RV, 32'h2008_0005, 1, 0, 0);
    add(0, 1, 0, 32'h0, 32'h44,              0, RV, 32'h2008_0005, 1, 0, 0);
    add(0, 1, 1, 32'hDEAD_BEEF, 32'h44,      0, RV, 32'h2008_0005, 1, 0, 0);
    add(0, 0, 0, 32'h0, 32'h44,              1, 32'h44, 32'h2008_0005, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      add(0, logic'(i % 2 == 0), 0, 32'hCAFE_0000, 32'h0, 1, 32'h44, 32'h2008_0005, 0, 1, 0);
    add(0, 1, 1, 32'h1111_1111, 32'h0,       0, 32'h44, 32'h1111_1111, 1, 1, 0);
    add(0, 0, 0, 32'h0, 32'h100,             1, 32'h100, 32'h1111_1111, 0, 2, 0);
    for (int k = 3; k <= 7; k++) begin
      add(0, 0, 1, 32'(k), 32'h0,            0, 32'h100, 32'(k), 1, 32'(k - 1), 0);
      add(0, 0, 0, 32'h0, 32'h100,           1, 32'h100, 32'(k), 0, 32'(k), 0);
    end
    add(0, 0, 1, 32'hAAAA_5555, 32'h0,       0, 32'h100, 32'hAAAA_5555, 1, 7, 0);
    add(1, 0, 1, 32'hBBBB_BBBB, 32'h200,     1, RV, 32'h0, 0, 0, 0);
    add(0, 0, 1, 32'h2222_2222, 32'h0,       0, RV, 32'h2222_2222, 1, 0, 0);
    add(0, 0, 0, 32'h0, 32'h46,              1, EXP_MIS_PC, 32'h2222_2222, 0, 1, EXP_ERR);
    add(0, 0, 1, 32'h3, 32'h0,               0, EXP_MIS_PC, 32'h3, 1, 1, EXP_ERR);
    add(0, 0, 0, 32'h0, 32'h80,              1, 32'h80, 32'h3, 0, 2, EXP_ERR);

    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].ack, vecs[i].data, vecs[i].nxt);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_pc,
                vecs[i].exp_instr, vecs[i].exp_valid, vecs[i].exp_cnt, vecs[i].exp_err);
      $display("vec %0d: pc=%h instr=%h valid=%0b cnt=%0d req=%0b", i, pc_atual,
               instrucao, instr_valida, contador_instr, imem_req);
    end

    // Right after reset release the fetch address must already be the vector.
    drive(1, 0, 0, 32'h0, 32'h0);
    step();
    drive(0, 0, 0, 32'h0, 32'h0);
    chk("post_reset.imem_req", {31'd0, imem_req}, 32'd1);
    chk("post_reset.imem_addr", imem_addr, RV);

    // PC wrap: load 0xFFFF_FFFC, then feed pc_mais4 back as next PC.
    drive(0, 0, 1, 32'h5, 32'h0);
    step();
    drive(0, 0, 0, 32'h0, 32'hFFFF_FFFC);
    step();
    chk("wrap.pc_atual", pc_atual, 32'hFFFF_FFFC);
    chk("wrap.pc_mais4", pc_mais4, 32'h0000_0000);
    drive(0, 0, 1, 32'h6, 32'h0);
    step();
    drive(0, 0, 0, 32'h0, pc_mais4);
    step();
    chk("wrap.pc_after", pc_atual, 32'h0000_0000);
    chk("wrap.cnt", contador_instr, 32'd2);
    $display("wrap: pc=%h pc_mais4=%h cnt=%0d", pc_atual, pc_mais4, contador_instr);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 400; t++) begin
      logic        r_rst, r_stl, r_ack;
      logic [31:0] r_data, r_nxt;
      r_rst  = (t == 0) || ($urandom_range(0, 31) == 0);
      r_stl  = $urandom_range(0, 2) == 0;
      r_ack  = $urandom_range(0, 1) == 1;
      r_data = $urandom;
      r_nxt  = $urandom;
      if ($urandom_range(0, 3) != 0) r_nxt[1:0] = 2'b00;
      drive(r_rst, r_stl, r_ack, r_data, r_nxt);
      model_edge(r_rst, r_stl, r_ack, r_data, r_nxt);
      step();
      check_all($sformatf("rnd%0d", t), logic'(!waiting_release), m_pc, m_instr,
                m_valid, m_cnt, m_err);
      $display("rnd %0d: rst=%0b stall=%0b ack=%0b pc=%h cnt=%0d", t, r_rst, r_stl,
               r_ack, pc_atual, contador_instr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
